vga_capture: RTL and testbench

Receive-side counterpart of the VGA generator. It samples the Hsync/Vsync/R/G/B stream one pixel per `clk` and recovers the active-area pixel coordinates. It then writes each visible pixel into a frame-buffer write port, so a generated frame (encrypted or decrypted image) can be read back and checked in hardware. One capture runs per `cap_start` request and ends with a `frame_done` pulse.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_sync_edge.sv | 41 ++++
 rtl/vga_capture.sv | 172 +++++++++++++++++
 tb/tb_vga_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA capture path:
//   - 640x480 @ 800x525 timing constants (active, porches, sync widths)
//   - CNT_W: width of the horizontal/vertical position counters
//   - cap_state_t: capture FSM states
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;

   // Position counters saturate at 2^CNT_W-1.
   localparam int CNT_W    = 12;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      SYNC,
      ACTIVE,
      DONE
   } cap_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// ---------------------------------------------------------------------------
// vga_sync_edge
// Two-flop sampler for one sync line plus assertion/deassertion edge flags.
// Ports:
//   clk, rst_n     pixel clock, async active-low reset
//   sync_raw       raw sync input from the generator
//   asserted       first sampled stage (s1) is at the asserted level
//   assert_edge    s2 deasserted, s1 asserted
//   deassert_edge  s2 asserted, s1 deasserted
// SYNC_POL gives the asserted level (0 = active-low).
// ---------------------------------------------------------------------------
module vga_sync_edge #(
   parameter bit SYNC_POL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_raw,
   output logic asserted,
   output logic assert_edge,
   output logic deassert_edge
);

   logic s1, s2;

   // Reset to the idle (deasserted) level so no edge fires out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= ~SYNC_POL;
         s2 <= ~SYNC_POL;
      end else begin
         // NOTE: non-blocking so s2 takes the old s1, forming a real shift.
         s1 <= sync_raw;
         s2 <= s1;
      end
   end

   assign asserted      = (s1 == SYNC_POL);
   assign assert_edge   = asserted  && (s2 != SYNC_POL);
   assign deassert_edge = !asserted && (s2 == SYNC_POL);

endmodule

// File: rtl/vga_capture.sv
// ---------------------------------------------------------------------------
// vga_capture
// Samples a VGA Hsync/Vsync/RGB stream, recovers active-area coordinates and
// writes each visible pixel of one complete frame to a frame-buffer port.
// Ports:
//   clk, rst_n          pixel clock, async active-low reset
//   Hsync, Vsync        sync inputs (asserted level = SYNC_POL)
//   R, G, B             8-bit colour inputs
//   cap_start           single-cycle request to capture the next full frame
//   busy                high from accepted cap_start until frame_done
//   wr_en/wr_addr/wr_data  frame-buffer write port, data = {R,G,B}
//   frame_done          one-cycle pulse after the last write
//   err                 sticky timing error, cleared by an accepted cap_start
// ---------------------------------------------------------------------------
module vga_capture #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_BP     = vga_pkg::V_BP,
   parameter bit SYNC_POL = 1'b0,
   parameter int ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Hsync,
   input  logic              Vsync,
   input  logic [7:0]        R,
   input  logic [7:0]        G,
   input  logic [7:0]        B,
   input  logic              cap_start,
   output logic              busy,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [23:0]       wr_data,
   output logic              frame_done,
   output logic              err
);

   import vga_pkg::*;

   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  H_FIRST  = CNT_W'(H_BP);
   localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(H_BP + H_ACTIVE - 1);
   localparam logic [CNT_W-1:0]  V_FIRST  = CNT_W'(V_BP);
   localparam logic [CNT_W-1:0]  V_LAST   = CNT_W'(V_BP + V_ACTIVE - 1);
   localparam logic [CNT_W-1:0]  PIX_LINE = CNT_W'(H_ACTIVE);
   localparam logic [ADDR_W-1:0] LINE_A   = ADDR_W'(H_ACTIVE);

   logic h_lvl, h_as, h_de;
   logic v_lvl, v_as, v_de;

   vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hsync (
      .clk(clk), .rst_n(rst_n), .sync_raw(Hsync),
      .asserted(h_lvl), .assert_edge(h_as), .deassert_edge(h_de)
   );

   vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vsync (
      .clk(clk), .rst_n(rst_n), .sync_raw(Vsync),
      .asserted(v_lvl), .assert_edge(v_as), .deassert_edge(v_de)
   );

   cap_state_t        state, state_next;
   logic [23:0]       rgb_d1;
   logic [CNT_W-1:0]  hcnt_q, vcnt_q, h_pos, v_pos, pix_cnt;
   logic              v_arm_q, v_arm, line_open;
   logic [ADDR_W-1:0] addr_cnt;
   logic              pix_hit, last_pix;
   logic              wr_fire, short_line, frame_abort, start_ok;

   // Position of the sample currently in s1/rgb_d1. v_arm marks that a
   // Vsync deassertion was seen and the row count restarts on the next
   // Hsync deassertion; until then the row number is stale and no write
   // may happen.
   always_comb begin
      v_arm = v_arm_q | v_de;
      h_pos = h_de ? '0 : ((hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 1'b1);
      v_pos = vcnt_q;
      if (h_de)
         v_pos = v_arm ? '0 : ((vcnt_q == CNT_MAX) ? vcnt_q : vcnt_q + 1'b1);
      pix_hit  = (h_pos >= H_FIRST) && (h_pos <= H_LAST) &&
                 (v_pos >= V_FIRST) && (v_pos <= V_LAST) &&
                 !(v_arm && !h_de) && !h_lvl && !v_lvl;
      last_pix = pix_hit && (h_pos == H_LAST) && (v_pos == V_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_next  = state;
      start_ok    = 1'b0;
      wr_fire     = 1'b0;
      short_line  = 1'b0;
      frame_abort = 1'b0;
      case (state)
         IDLE: if (cap_start) begin
            start_ok   = 1'b1;
            state_next = ARM;
         end
         ARM:  if (v_as) state_next = SYNC;
         SYNC: if (v_de) state_next = ACTIVE;
         ACTIVE: begin
            if (v_as) begin
               frame_abort = 1'b1;
               state_next  = SYNC;
            end else begin
               short_line = h_as && line_open && (pix_cnt != PIX_LINE);
               wr_fire    = pix_hit;
               if (last_pix) state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_d1     <= '0;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         v_arm_q    <= 1'b0;
         pix_cnt    <= '0;
         line_open  <= 1'b0;
         addr_cnt   <= '0;
         busy       <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         rgb_d1     <= {R, G, B};
         hcnt_q     <= h_pos;
         vcnt_q     <= v_pos;
         v_arm_q    <= h_de ? 1'b0 : v_arm;
         busy       <= (state_next != IDLE);
         wr_en      <= wr_fire;
         frame_done <= (state == DONE);
         if (wr_fire) begin
            wr_addr <= addr_cnt;
            wr_data <= rgb_d1;
         end

         if (start_ok)                       err <= 1'b0;
         else if (short_line || frame_abort) err <= 1'b1;

         // Running address: a short line skips the unwritten remainder so
         // the next row still starts on a line boundary.
         if (state == SYNC || frame_abort) begin
            addr_cnt  <= '0;
            pix_cnt   <= '0;
            line_open <= 1'b0;
         end else if (short_line) begin
            addr_cnt  <= addr_cnt + LINE_A - ADDR_W'(pix_cnt);
            pix_cnt   <= '0;
            line_open <= 1'b0;
         end else if (wr_fire) begin
            addr_cnt  <= addr_cnt + 1'b1;
            pix_cnt   <= pix_cnt + 1'b1;
            line_open <= 1'b1;
         end else if (h_as) begin
            pix_cnt   <= '0;
            line_open <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_capture.sv
// ---------------------------------------------------------------------------
// tb_vga_capture
// Directed bench on a reduced 8x4 geometry (16x9 totals). Two instances run
// in parallel: SYNC_POL=0 fed active-low syncs, SYNC_POL=1 fed the inverted
// syncs; both must produce identical captures.
// ---------------------------------------------------------------------------
module tb_vga_capture;

   localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
   localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 2;
   localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int ADDR_W = 5;
   localparam int SHORT_LEN = 5;

   logic clk = 1'b0;
   logic rst_n;
   logic hsync0, vsync0, hsync1, vsync1;
   logic [7:0] r, g, b;
   logic cap_start;

   logic busy0, wr_en0, frame_done0, err0;
   logic busy1, wr_en1, frame_done1, err1;
   logic [ADDR_W-1:0] wr_addr0, wr_addr1;
   logic [23:0] wr_data0, wr_data1;

   always #5 clk = ~clk;

   vga_capture #(.H_ACTIVE(H_ACTIVE), .H_BP(H_BP), .V_ACTIVE(V_ACTIVE),
                 .V_BP(V_BP), .SYNC_POL(1'b0), .ADDR_W(ADDR_W)) dut0 (
      .clk(clk), .rst_n(rst_n), .Hsync(hsync0), .Vsync(vsync0),
      .R(r), .G(g), .B(b), .cap_start(cap_start),
      .busy(busy0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
      .frame_done(frame_done0), .err(err0));

   vga_capture #(.H_ACTIVE(H_ACTIVE), .H_BP(H_BP), .V_ACTIVE(V_ACTIVE),
                 .V_BP(V_BP), .SYNC_POL(1'b1), .ADDR_W(ADDR_W)) dut1 (
      .clk(clk), .rst_n(rst_n), .Hsync(hsync1), .Vsync(vsync1),
      .R(r), .G(g), .B(b), .cap_start(cap_start),
      .busy(busy1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .frame_done(frame_done1), .err(err1));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [23:0] hist1, hist2;

   int wr_cnt[2], first_addr[2], last_addr[2], row2_addr[2];
   int seq_bad[2], lat_bad[2], done_cnt[2], done_cyc[2], last_wr_cyc[2];
   logic [23:0] first_data[2], last_data[2];
   logic busy_at_last_wr[2], busy_at_done[2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] out_vec(input int i);
      if (i == 0) return 64'({busy0, wr_en0, frame_done0, err0, wr_addr0, wr_data0});
      return 64'({busy1, wr_en1, frame_done1, err1, wr_addr1, wr_data1});
   endfunction

   function automatic logic get_busy(input int i);
      return (i == 0) ? busy0 : busy1;
   endfunction

   function automatic logic get_err(input int i);
      return (i == 0) ? err0 : err1;
   endfunction

   task automatic clear_stats();
      for (int i = 0; i < 2; i++) begin
         wr_cnt[i] = 0; first_addr[i] = -1; last_addr[i] = -1; row2_addr[i] = -1;
         seq_bad[i] = 0; lat_bad[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0;
         last_wr_cyc[i] = 0; first_data[i] = '0; last_data[i] = '0;
         busy_at_last_wr[i] = 1'b0; busy_at_done[i] = 1'b1;
      end
   endtask

   task automatic sample_dut(input int i, input logic bz, input logic we, input logic fd,
                             input logic [ADDR_W-1:0] a, input logic [23:0] d);
      if (we) begin
         if (wr_cnt[i] == 0) begin
            first_addr[i] = int'(a);
            first_data[i] = d;
         end else if (int'(a) != last_addr[i] + 1) begin
            seq_bad[i]++;
         end
         if (d !== hist2) lat_bad[i]++;
         if (d[15:8] == 8'd2 && row2_addr[i] < 0) row2_addr[i] = int'(a);
         last_addr[i] = int'(a);
         last_data[i] = d;
         last_wr_cyc[i] = cyc;
         busy_at_last_wr[i] = bz;
         wr_cnt[i]++;
      end
      if (fd) begin
         done_cnt[i]++;
         done_cyc[i] = cyc;
         busy_at_done[i] = bz;
      end
   endtask

   // One pixel clock: observe outputs settled from the last rising edge,
   // then drive the next input sample.
   task automatic tick(input logic hs, input logic vs, input logic [23:0] rgb, input logic cap);
      @(negedge clk);
      cyc++;
      sample_dut(0, busy0, wr_en0, frame_done0, wr_addr0, wr_data0);
      sample_dut(1, busy1, wr_en1, frame_done1, wr_addr1, wr_data1);
      hsync0 = ~hs; vsync0 = ~vs;
      hsync1 = hs;  vsync1 = vs;
      {r, g, b} = rgb;
      cap_start = cap;
      hist2 = hist1;
      hist1 = rgb;
   endtask

   // Line order: sync, back porch, active, front porch. The frame stops
   // at stop_p of its last line; short_l ends that line after SHORT_LEN
   // active pixels. cap_start pulses at (cap_l,cap_p) and (cap_l2,cap_p2).
   task automatic frame(input int nl, input int stop_p, input int cap_l, input int cap_p,
                        input int short_l, input int cap_l2, input int cap_p2);
      for (int l = 0; l < nl; l++) begin
         for (int p = 0; p < H_TOT; p++) begin
            int col, row;
            logic [23:0] rgb;
            if (l == nl - 1 && p >= stop_p) break;
            if (l == short_l && p >= H_SYNC + H_BP + SHORT_LEN) break;
            col = p - H_SYNC - H_BP;
            row = l - V_SYNC - V_BP;
            rgb = '0;
            if (col >= 0 && col < H_ACTIVE && row >= 0 && row < V_ACTIVE)
               rgb = {8'(col), 8'(row), 8'h5A};
            tick(p < H_SYNC, l < V_SYNC, rgb,
                 (l == cap_l && p == cap_p) || (l == cap_l2 && p == cap_p2));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      hsync0 = 1'b1; vsync0 = 1'b1; hsync1 = 1'b0; vsync1 = 1'b0;
      r = '0; g = '0; b = '0; cap_start = 1'b0;
      hist1 = '0; hist2 = '0;
      clear_stats();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) check($sformatf("reset_outputs%0d", i), out_vec(i), 64'd0);
      rst_n = 1'b1;

      // Full capture requested mid-frame: the frame in flight is dropped.
      frame(V_TOT, H_TOT, 5, 4, -1, -1, -1);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("armed_busy%0d", i), 64'(get_busy(i)), 64'd1);
         check($sformatf("inflight_writes%0d", i), 64'(wr_cnt[i]), 64'd0);
      end
      clear_stats();
      frame(V_TOT, H_TOT, -1, -1, -1, -1, -1);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("writes%0d", i), 64'(wr_cnt[i]), 64'd32);
         check($sformatf("first_addr%0d", i), 64'(first_addr[i]), 64'd0);
         check($sformatf("first_data%0d", i), 64'(first_data[i]), 64'h00005A);
         check($sformatf("last_addr%0d", i), 64'(last_addr[i]), 64'd31);
         check($sformatf("last_data%0d", i), 64'(last_data[i]), 64'h07035A);
         check($sformatf("addr_seq%0d", i), 64'(seq_bad[i]), 64'd0);
         check($sformatf("latency%0d", i), 64'(lat_bad[i]), 64'd0);
         check($sformatf("done_cnt%0d", i), 64'(done_cnt[i]), 64'd1);
         check($sformatf("done_delay%0d", i), 64'(done_cyc[i] - last_wr_cyc[i]), 64'd1);
         check($sformatf("busy_last_wr%0d", i), 64'(busy_at_last_wr[i]), 64'd1);
         check($sformatf("busy_at_done%0d", i), 64'(busy_at_done[i]), 64'd0);
         check($sformatf("err_clean%0d", i), 64'(get_err(i)), 64'd0);
      end

      // cap_start during ACTIVE (row 1) and during DONE is ignored.
      frame(V_TOT, H_TOT, 6, 0, -1, -1, -1);
      clear_stats();
      frame(V_TOT, H_TOT, 5, 8, -1, 7, 15);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("ign_writes%0d", i), 64'(wr_cnt[i]), 64'd32);
         check($sformatf("ign_done%0d", i), 64'(done_cnt[i]), 64'd1);
      end
      clear_stats();
      frame(V_TOT, H_TOT, -1, -1, -1, -1, -1);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("no_second_writes%0d", i), 64'(wr_cnt[i]), 64'd0);
         check($sformatf("no_second_busy%0d", i), 64'(get_busy(i)), 64'd0);
      end

      // Row 1 cut to SHORT_LEN pixels.
      frame(V_TOT, H_TOT, 6, 0, -1, -1, -1);
      clear_stats();
      frame(V_TOT, H_TOT, -1, -1, 5, -1, -1);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("short_err%0d", i), 64'(get_err(i)), 64'd1);
         check($sformatf("short_writes%0d", i), 64'(wr_cnt[i]), 64'd29);
         check($sformatf("short_row2_addr%0d", i), 64'(row2_addr[i]), 64'd16);
         check($sformatf("short_last_addr%0d", i), 64'(last_addr[i]), 64'd31);
         check($sformatf("short_done%0d", i), 64'(done_cnt[i]), 64'd1);
      end

      // Vsync restarts the frame where row 2 would begin.
      frame(V_TOT, H_TOT, 6, 0, -1, -1, -1);
      for (int i = 0; i < 2; i++) check($sformatf("err_cleared%0d", i), 64'(get_err(i)), 64'd0);
      clear_stats();
      frame(V_SYNC + V_BP + 2, H_TOT, -1, -1, -1, -1, -1);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("abort_writes%0d", i), 64'(wr_cnt[i]), 64'd16);
         check($sformatf("abort_no_done%0d", i), 64'(done_cnt[i]), 64'd0);
      end
      clear_stats();
      frame(V_TOT, H_TOT, -1, -1, -1, -1, -1);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("abort_err%0d", i), 64'(get_err(i)), 64'd1);
         check($sformatf("abort_re_writes%0d", i), 64'(wr_cnt[i]), 64'd32);
         check($sformatf("abort_re_first%0d", i), 64'(first_addr[i]), 64'd0);
         check($sformatf("abort_re_seq%0d", i), 64'(seq_bad[i]), 64'd0);
         check($sformatf("abort_re_done%0d", i), 64'(done_cnt[i]), 64'd1);
      end

      // Reset in the middle of row 1 while writes are in progress.
      frame(V_TOT, H_TOT, 6, 0, -1, -1, -1);
      clear_stats();
      frame(6, 8, -1, -1, -1, -1, -1);
      for (int i = 0; i < 2; i++) check($sformatf("pre_reset_writes%0d", i), 64'(wr_cnt[i]), 64'd8);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) check($sformatf("mid_reset_outputs%0d", i), out_vec(i), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_stats();
      frame(V_TOT, H_TOT, -1, -1, -1, -1, -1);
      frame(V_TOT, H_TOT, -1, -1, -1, -1, -1);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("post_reset_writes%0d", i), 64'(wr_cnt[i]), 64'd0);
         check($sformatf("post_reset_busy%0d", i), 64'(get_busy(i)), 64'd0);
      end
      frame(V_TOT, H_TOT, 6, 0, -1, -1, -1);
      clear_stats();
      frame(V_TOT, H_TOT, -1, -1, -1, -1, -1);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("recover_writes%0d", i), 64'(wr_cnt[i]), 64'd32);
         check($sformatf("recover_last%0d", i), 64'(last_data[i]), 64'h07035A);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
